// File: rtl/irb_scanout_if.sv
// Bundle of the IRB capture port, the controller done level and the
// valid/ready pixel stream with its frame markers and status flags.
interface irb_scanout_if #(
    parameter int DIM = 8,
    parameter int PW  = 8
);
    localparam int AW = $clog2(DIM * DIM);
    localparam int SW = PW + AW;

    // Controller side: image writes and done level
    logic          IRB_RW;
    logic [AW-1:0] IRB_A;
    logic [PW-1:0] IRB_D;
    logic          ctrl_done;

    // Panel driver side: pixel stream
    logic [PW-1:0] px_data;
    logic          px_valid;
    logic          px_ready;
    logic          px_sof;
    logic          px_eol;
    logic          px_eof;

    // Status
    logic [SW-1:0] px_sum;
    logic [7:0]    frame_cnt;
    logic          busy;
    logic          err_incomplete;
    logic          err_overrun;

    // Environment: drives writes, done and ready; observes the stream
    modport master (
        output IRB_RW, IRB_A, IRB_D, ctrl_done, px_ready,
        input  px_data, px_valid, px_sof, px_eol, px_eof,
        input  px_sum, frame_cnt, busy, err_incomplete, err_overrun
    );

    // Scan-out block
    modport slave (
        input  IRB_RW, IRB_A, IRB_D, ctrl_done, px_ready,
        output px_data, px_valid, px_sof, px_eol, px_eof,
        output px_sum, frame_cnt, busy, err_incomplete, err_overrun
    );
endinterface

// File: rtl/irb_scanout.sv
// irb_scanout: captures the DIM x DIM image the LCD controller writes over the
// IRB port and, on each rising edge of ctrl_done, streams it in raster order
// over a valid/ready pixel bus with frame markers, a running sum and flags.
module irb_scanout #(
    parameter int DIM = 8,
    parameter int PW  = 8
) (
    input  logic         clk,
    input  logic         reset,
    irb_scanout_if.slave bus
);
    localparam int NPIX = DIM * DIM;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(DIM);
    localparam int SW   = PW + AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(DIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic            start_q, start_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   px_data_q, px_data_d;
    logic            px_valid_q, px_valid_d;
    logic            px_sof_q, px_sof_d;
    logic            px_eol_q, px_eol_d;
    logic            px_eof_q, px_eof_d;
    logic [SW-1:0]   px_sum_q, px_sum_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [NPIX-1:0] bitmap_q, bitmap_d;
    logic            err_inc_q, err_inc_d;
    logic            err_ovr_q, err_ovr_d;
    logic [PW-1:0]   mem_q [NPIX];
    logic [PW-1:0]   mem_d [NPIX];

    logic            idle;
    logic            wr_req;
    logic            wr_en;
    logic [NPIX-1:0] wr_sel;
    logic [AW-1:0]   idx_next;

    // A write is only honoured while the scan engine is idle; a write seen
    // in LOAD/SCAN is dropped and flagged as an overrun instead.
    assign idle     = (state_q == ST_IDLE);
    assign wr_req   = ~bus.IRB_RW;
    assign wr_en    = wr_req & idle;
    assign idx_next = idx_q + AW'(1);

    // One-hot write decode; the same vector updates memory and the bitmap
    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (bus.IRB_A == AW'(gi));
        end
    endgenerate

    // Next-state of the pixel memory: last write to an address wins
    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_sel[i]) begin
                mem_d[i] = bus.IRB_D;
            end
        end
    end

    // Pixel memory: cleared by reset so unwritten addresses read back zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Done edge detection and sticky overrun. The start event is registered
    // and only accepted while idle, so a done edge during a frame is lost
    // and a held-high done never retriggers.
    always_comb begin
        done_d    = bus.ctrl_done;
        start_d   = bus.ctrl_done & ~done_q & idle;
        err_ovr_d = err_ovr_q | (wr_req & ~idle);
    end

    // Scan FSM next-state and stream outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        px_data_d   = px_data_q;
        px_valid_d  = px_valid_q;
        px_sof_d    = px_sof_q;
        px_eol_d    = px_eol_q;
        px_eof_d    = px_eof_q;
        px_sum_d    = px_sum_q;
        frame_cnt_d = frame_cnt_q;
        bitmap_d    = bitmap_q | wr_sel;
        err_inc_d   = err_inc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    // A write in this same cycle still counts towards completeness
                    err_inc_d = ~&(bitmap_q | wr_sel);
                    px_sum_d  = '0;
                    state_d   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                px_data_d  = mem_q[0];
                px_valid_d = 1'b1;
                px_sof_d   = 1'b1;
                px_eol_d   = 1'b0;
                px_eof_d   = 1'b0;
                idx_d      = '0;
                state_d    = ST_SCAN;
            end

            ST_SCAN: begin
                // Without ready everything holds, so a stalled beat is stable
                if (px_valid_q && bus.px_ready) begin
                    px_sum_d = px_sum_q + SW'(px_data_q);
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_next;
                        px_data_d = mem_q[idx_next];
                        px_sof_d  = 1'b0;
                        px_eol_d  = (idx_next[CW-1:0] == LAST_COL);
                        px_eof_d  = (idx_next == LAST_IDX);
                    end else begin
                        px_valid_d  = 1'b0;
                        px_sof_d    = 1'b0;
                        px_eol_d    = 1'b0;
                        px_eof_d    = 1'b0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        bitmap_d    = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            idx_q       <= '0;
            px_data_q   <= '0;
            px_valid_q  <= 1'b0;
            px_sof_q    <= 1'b0;
            px_eol_q    <= 1'b0;
            px_eof_q    <= 1'b0;
            px_sum_q    <= '0;
            frame_cnt_q <= '0;
            bitmap_q    <= '0;
            err_inc_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            start_q     <= start_d;
            idx_q       <= idx_d;
            px_data_q   <= px_data_d;
            px_valid_q  <= px_valid_d;
            px_sof_q    <= px_sof_d;
            px_eol_q    <= px_eol_d;
            px_eof_q    <= px_eof_d;
            px_sum_q    <= px_sum_d;
            frame_cnt_q <= frame_cnt_d;
            bitmap_q    <= bitmap_d;
            err_inc_q   <= err_inc_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign bus.px_data        = px_data_q;
    assign bus.px_valid       = px_valid_q;
    assign bus.px_sof         = px_sof_q;
    assign bus.px_eol         = px_eol_q;
    assign bus.px_eof         = px_eof_q;
    assign bus.px_sum         = px_sum_q;
    assign bus.frame_cnt      = frame_cnt_q;
    assign bus.busy           = ~idle;
    assign bus.err_incomplete = err_inc_q;
    assign bus.err_overrun    = err_ovr_q;
endmodule

// File: tb/tb_irb_scanout.sv
// Bench for irb_scanout: directed frames against a frame-level model
// (image snapshot, beat index, running sum) plus literal expectations.
module tb_irb_scanout;
    logic clk = 1'b0;
    logic reset;

    irb_scanout_if #(.DIM(8), .PW(8)) bus ();

    irb_scanout #(.DIM(8), .PW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- frame-level model ----------------
    logic [7:0]  m_mem [64];
    logic [7:0]  m_img [64];
    bit   [63:0] m_written;
    int          m_stage;   // 0 idle, 1 start seen, 2 frame opened, 3 streaming
    int          m_k;
    int          m_sum;
    int          m_fc;
    bit          m_busy, m_valid, m_inc, m_ovr, m_prev_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                m_mem[i] = 8'd0;
                m_img[i] = 8'd0;
            end
            m_written = '0; m_stage = 0; m_k = 0; m_sum = 0; m_fc = 0;
            m_busy = 0; m_valid = 0; m_inc = 0; m_ovr = 0; m_prev_done = 0;
        end else begin
            bit start_ev;
            start_ev    = bus.ctrl_done && !m_prev_done && (m_stage == 0);
            m_prev_done = bus.ctrl_done;
            if (bus.IRB_RW == 1'b0) begin
                if (m_busy) m_ovr = 1;
                else begin
                    m_mem[bus.IRB_A]     = bus.IRB_D;
                    m_written[bus.IRB_A] = 1'b1;
                end
            end
            case (m_stage)
                0: if (start_ev) m_stage = 1;
                1: begin
                    m_img   = m_mem;
                    m_inc   = (m_written != {64{1'b1}});
                    m_sum   = 0;
                    m_busy  = 1;
                    m_stage = 2;
                end
                2: begin
                    m_valid = 1; m_k = 0; m_stage = 3;
                end
                default: begin
                    if (bus.px_ready) begin
                        m_sum += int'(m_img[m_k]);
                        if (m_k == 63) begin
                            m_valid = 0; m_busy = 0;
                            m_fc = (m_fc + 1) % 256;
                            m_written = '0;
                            m_stage = 0;
                        end else m_k++;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid", bus.px_valid, m_valid);
        if (m_valid) chk("data", bus.px_data, m_img[m_k]);
        chk("sof", bus.px_sof, m_valid && (m_k == 0));
        chk("eol", bus.px_eol, m_valid && (m_k % 8 == 7));
        chk("eof", bus.px_eof, m_valid && (m_k == 63));
        chk("sum", bus.px_sum, m_sum);
        chk("frame_cnt", bus.frame_cnt, m_fc);
        chk("busy", bus.busy, m_busy);
        chk("err_incomplete", bus.err_incomplete, m_inc);
        chk("err_overrun", bus.err_overrun, m_ovr);
    end

    // ---------------- beat capture ----------------
    logic [7:0]  cap_data [64];
    bit   [63:0] cap_sof, cap_eol, cap_eof;
    int          cap_n;
    logic [7:0]  exp_img [64];

    always @(negedge clk) begin
        if (!reset && bus.px_valid && bus.px_ready) begin
            if (cap_n < 64) begin
                cap_data[cap_n] = bus.px_data;
                cap_sof[cap_n]  = bus.px_sof;
                cap_eol[cap_n]  = bus.px_eol;
                cap_eof[cap_n]  = bus.px_eof;
            end
            cap_n++;
        end
    end

    function automatic logic [7:0] pix_val(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'd255;
            2:       return 8'(i + 1);
            default: return 8'(2 * i);
        endcase
    endfunction

    task automatic set_exp(input int mode);
        for (int i = 0; i < 64; i++) exp_img[i] = pix_val(mode, i);
    endtask

    // Mode 2 skips address 63
    task automatic write_img(input int mode);
        for (int i = 0; i < 64; i++) begin
            if (mode == 2 && i == 63) continue;
            bus.IRB_RW = 1'b0;
            bus.IRB_A  = 6'(i);
            bus.IRB_D  = pix_val(mode, i);
            tick();
        end
        bus.IRB_RW = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        bus.ctrl_done = 1'b0;
        bus.IRB_RW    = 1'b1;
        bus.px_ready  = 1'b0;
        reset = 1'b1;
        #1;
        chk({tag, "_valid"}, bus.px_valid, 0);
        chk({tag, "_sof"}, bus.px_sof, 0);
        chk({tag, "_data"}, bus.px_data, 0);
        chk({tag, "_sum"}, bus.px_sum, 0);
        chk({tag, "_fc"}, bus.frame_cnt, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ovr"}, bus.err_overrun, 0);
        chk({tag, "_inc"}, bus.err_incomplete, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // pat 0: ready always high; pat 1: ready 1 cycle on, 2 off.
    // inj: issue one write to address 5 while the frame is streaming.
    task automatic run_frame(input int pat, input bit inj, input string tag);
        int fc0;
        bit fin, injected;
        fin = 0; injected = 0;
        cap_n = 0; cap_sof = '0; cap_eol = '0; cap_eof = '0;
        bus.ctrl_done = 1'b0;
        tick();
        fc0 = int'(bus.frame_cnt);
        bus.ctrl_done = 1'b1;          // first sampled high at edge E
        tick();
        chk({tag, "_lat_e_valid"}, bus.px_valid, 0);
        chk({tag, "_lat_e_busy"}, bus.busy, 0);
        tick();
        chk({tag, "_lat_e1_valid"}, bus.px_valid, 0);
        chk({tag, "_lat_e1_busy"}, bus.busy, 1);
        tick();
        chk({tag, "_lat_e2_valid"}, bus.px_valid, 1);
        chk({tag, "_lat_e2_sof"}, bus.px_sof, 1);
        chk({tag, "_lat_e2_data"}, bus.px_data, exp_img[0]);
        for (int c = 0; c < 1000 && !fin; c++) begin
            bus.px_ready = (pat == 0) ? 1'b1 : (c % 3 == 0);
            if (inj && !injected && cap_n >= 2) begin
                bus.IRB_RW = 1'b0; bus.IRB_A = 6'd5; bus.IRB_D = 8'hAA;
                injected = 1;
            end else begin
                bus.IRB_RW = 1'b1;
            end
            tick();
            if (!bus.busy && int'(bus.frame_cnt) != fc0) fin = 1;
        end
        bus.px_ready = 1'b0;
        bus.IRB_RW   = 1'b1;
        chk({tag, "_finished"}, fin, 1);
    endtask

    task automatic frame_check(input string tag, input int exp_sum);
        int nm;
        nm = 0;
        chk({tag, "_beats"}, cap_n, 64);
        for (int i = 0; i < 64; i++) if (cap_data[i] !== exp_img[i]) nm++;
        chk({tag, "_img_mismatches"}, nm, 0);
        chk({tag, "_sof_vec"}, cap_sof, 64'h0000_0000_0000_0001);
        chk({tag, "_eol_vec"}, cap_eol, 64'h8080_8080_8080_8080);
        chk({tag, "_eof_vec"}, cap_eof, 64'h8000_0000_0000_0000);
        chk({tag, "_sum"}, bus.px_sum, exp_sum);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.IRB_RW = 1'b1; bus.IRB_A = '0; bus.IRB_D = '0;
        bus.ctrl_done = 1'b0; bus.px_ready = 1'b0;
        cap_n = 0;
        tick();
        chk("rst_valid", bus.px_valid, 0);
        chk("rst_sum", bus.px_sum, 0);
        chk("rst_fc", bus.frame_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.err_overrun, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: ramp image, ready always high
        write_img(0); set_exp(0);
        run_frame(0, 0, "t1");
        frame_check("t1", 2016);
        chk("t1_fc", bus.frame_cnt, 1);
        chk("t1_inc", bus.err_incomplete, 0);

        // 2: same image, ready 1-on/2-off
        run_frame(1, 0, "t2");
        frame_check("t2", 2016);
        chk("t2_fc", bus.frame_cnt, 2);

        // 3: all 255, done held high afterwards
        do_reset("t3_rst");
        write_img(1); set_exp(1);
        run_frame(0, 0, "t3");
        frame_check("t3", 16320);
        repeat (200) tick();
        chk("t3_fc_held", bus.frame_cnt, 1);
        chk("t3_busy_held", bus.busy, 0);
        chk("t3_valid_held", bus.px_valid, 0);
        bus.ctrl_done = 1'b0;

        // 4: incomplete image, then complete rewrite
        do_reset("t4_rst");
        write_img(2); set_exp(2); exp_img[63] = 8'd0;
        run_frame(0, 0, "t4a");
        frame_check("t4a", 2016);
        chk("t4a_inc", bus.err_incomplete, 1);
        chk("t4a_px63", cap_data[63], 0);
        write_img(3); set_exp(3);
        run_frame(0, 0, "t4b");
        frame_check("t4b", 4032);
        chk("t4b_inc", bus.err_incomplete, 0);

        // 5: write during SCAN is dropped and flagged
        do_reset("t5_rst");
        write_img(0); set_exp(0);
        run_frame(0, 1, "t5a");
        frame_check("t5a", 2016);
        chk("t5a_ovr", bus.err_overrun, 1);
        chk("t5a_px5", cap_data[5], 5);
        run_frame(0, 0, "t5b");
        frame_check("t5b", 2016);
        chk("t5b_ovr", bus.err_overrun, 1);
        chk("t5b_inc", bus.err_incomplete, 1);
        chk("t5b_px5", cap_data[5], 5);

        // 6: reset at beat 20, then a clean frame
        do_reset("t6_rst");
        write_img(0); set_exp(0);
        cap_n = 0;
        bus.px_ready  = 1'b1;
        bus.ctrl_done = 1'b1;
        for (int c = 0; c < 300 && cap_n < 20; c++) tick();
        chk("t6_beats20", cap_n, 20);
        chk("t6_sum20", bus.px_sum, 190);
        do_reset("t6_abort");
        write_img(0); set_exp(0);
        run_frame(0, 0, "t6");
        frame_check("t6", 2016);
        chk("t6_fc", bus.frame_cnt, 1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
